// File: rtl/dma_pkg.sv
// Shared definitions for the DMA arbiter slice: default bus widths, beat size
// and the width of a core index.
package dma_pkg;

    localparam int unsigned ADDR_W_DEF = 48;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned BEAT_BYTES = 8;

    // A single core still needs one index bit so that vectors never collapse to zero width.
    function automatic int unsigned core_id_w(input int unsigned num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of core indices that tracks the issuing core of each
// outstanding read, in issue order.
module tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port among several cores;
// in-order read responses are steered back to their issuer via a tag FIFO.
module dma_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_gnt,
    output logic [NUM_CORES-1:0]          core_valid,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          err_orphan,
    output logic [$clog2(TAG_DEPTH):0]    dbg_outstanding
);

    localparam int unsigned CID_W = core_id_w(NUM_CORES);
    typedef logic [CID_W-1:0] core_id_t;

    // First eligible core at or above ptr, wrapping around.
    function automatic core_id_t rr_pick(input logic [NUM_CORES-1:0] elig,
                                         input core_id_t              ptr);
        core_id_t    win;
        logic        found;
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(ptr) + i) % NUM_CORES;
            if (!found && elig[idx]) begin
                win   = core_id_t'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    core_id_t              rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]  core_valid_q, core_valid_d;
    logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;
    logic                  err_orphan_q, err_orphan_d;

    logic [NUM_CORES-1:0]  elig;
    core_id_t              winner;
    logic                  fire;
    logic                  tag_push;
    logic                  tag_pop;
    logic                  tag_full;
    logic                  tag_empty;
    core_id_t              tag_head;

    always_comb begin
        elig      = core_req & (core_we | {NUM_CORES{~tag_full}});
        winner    = rr_pick(elig, rr_ptr_q);
        mem_req   = |elig;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_we    = core_we[winner];
            mem_addr  = core_addr[winner*ADDR_W +: ADDR_W];
            mem_wdata = core_wdata[winner*DATA_W +: DATA_W];
        end

        fire     = mem_req & mem_ready;
        core_gnt = '0;
        rr_ptr_d = rr_ptr_q;
        tag_push = 1'b0;
        if (fire) begin
            core_gnt[winner] = 1'b1;
            rr_ptr_d = (winner == core_id_t'(NUM_CORES-1)) ? '0 : winner + 1'b1;
            tag_push = ~core_we[winner];
        end
    end

    always_comb begin
        tag_pop      = mem_rvalid & ~tag_empty;
        core_valid_d = '0;
        core_rdata_d = core_rdata_q;
        err_orphan_d = err_orphan_q | (mem_rvalid & tag_empty);
        if (tag_pop) begin
            core_valid_d[tag_head] = 1'b1;
            core_rdata_d           = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            core_valid_q <= '0;
            core_rdata_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            core_valid_q <= core_valid_d;
            core_rdata_q <= core_rdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (CID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (winner),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (dbg_outstanding)
    );

    assign core_valid = core_valid_q;
    assign core_rdata = core_rdata_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: single read, round-robin order, write
// streaming, full tag FIFO, backpressure and orphaned responses after reset.
module tb_dma_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_gnt;
    logic [NC-1:0]     core_valid;
    logic [DW-1:0]     core_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic              err_orphan;
    logic [3:0]        dbg_outstanding;

    int checks;
    int failures;
    int bad;

    dma_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_req        (core_req),
        .core_we         (core_we),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_gnt        (core_gnt),
        .core_valid      (core_valid),
        .core_rdata      (core_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .err_orphan      (err_orphan),
        .dbg_outstanding (dbg_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        core_addr[c*AW +: AW] = a;
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        checks = 0; failures = 0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();

        chk("rst_core_valid", 64'(core_valid), 64'h0);
        chk("rst_core_rdata", core_rdata, 64'h0);
        chk("rst_err_orphan", 64'(err_orphan), 64'h0);
        chk("rst_dbg", 64'(dbg_outstanding), 64'h0);
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_gnt", 64'(core_gnt), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        rst = 1'b0;
        tick();

        // Single read from core 2
        core_req = 4'b0100; core_we = 4'b0000; set_addr(2, 48'h100); mem_ready = 1'b1;
        settle();
        chk("rd_gnt", 64'(core_gnt), 64'h4);
        chk("rd_mem_req", 64'(mem_req), 64'h1);
        chk("rd_mem_addr", 64'(mem_addr), 64'h100);
        chk("rd_mem_we", 64'(mem_we), 64'h0);
        tick();
        core_req = '0;
        chk("rd_outstanding", 64'(dbg_outstanding), 64'h1);
        tick(); tick();
        chk("rd_no_early_valid", 64'(core_valid), 64'h0);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        chk("rd_valid", 64'(core_valid), 64'h4);
        chk("rd_rdata", core_rdata, 64'hDEAD);
        chk("rd_outstanding_0", 64'(dbg_outstanding), 64'h0);
        tick();
        chk("rd_valid_drop", 64'(core_valid), 64'h0);

        // Round-robin with all four cores reading
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int k = 0; k < 4; k++) set_addr(k, 48'(48'h1000 + k * 8));
        core_req = 4'b1111; core_we = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("rr_gnt%0d", k), 64'(core_gnt), 64'(rr_exp[k]));
            tick();
        end
        core_req = '0;
        chk("rr_outstanding", 64'(dbg_outstanding), 64'h5);
        for (int k = 0; k < 5; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'(64'hA0 + k);
            tick();
            chk($sformatf("rr_valid%0d", k), 64'(core_valid), 64'(rr_exp[k]));
            chk($sformatf("rr_rdata%0d", k), core_rdata, 64'(64'hA0 + k));
        end
        mem_rvalid = 1'b0;
        chk("rr_outstanding_0", 64'(dbg_outstanding), 64'h0);

        // Write stream from core 1
        core_req = 4'b0010; core_we = 4'b0010; set_addr(1, 48'h2000);
        core_wdata[1*DW +: DW] = 64'h1234_5678_9ABC_DEF0;
        settle();
        chk("ws_wdata", mem_wdata, 64'h1234_5678_9ABC_DEF0);
        bad = 0;
        tick();
        for (int i = 0; i < 4096; i++) begin
            if (i != 0) settle();
            if (core_gnt !== 4'b0010 || mem_we !== 1'b1 || dbg_outstanding !== 4'd0) bad++;
            tick();
        end
        core_req = '0; core_we = '0;
        chk("ws_bad_beats", 64'(bad), 64'h0);
        chk("ws_outstanding", 64'(dbg_outstanding), 64'h0);

        // Full tag FIFO: reads blocked, writes still granted
        rst = 1'b1; tick(); rst = 1'b0; tick();
        core_req = 4'b0001; core_we = 4'b0000;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (core_gnt !== 4'b0001) bad++;
            tick();
        end
        chk("full_fill_bad", 64'(bad), 64'h0);
        chk("full_outstanding", 64'(dbg_outstanding), 64'h8);
        core_req = 4'b1001; core_we = 4'b1000;
        settle();
        chk("full_wr_gnt", 64'(core_gnt), 64'h8);
        chk("full_wr_we", 64'(mem_we), 64'h1);
        tick();
        core_req = 4'b0001; core_we = 4'b0000;
        mem_rvalid = 1'b1; mem_rdata = 64'h55;
        settle();
        chk("full_rd_blocked", 64'(core_gnt), 64'h0);
        chk("full_rd_no_req", 64'(mem_req), 64'h0);
        tick();
        mem_rvalid = 1'b0;
        chk("full_pop_valid", 64'(core_valid), 64'h1);
        chk("full_after_pop", 64'(dbg_outstanding), 64'h7);
        settle();
        chk("full_rd_regrant", 64'(core_gnt), 64'h1);
        tick();
        core_req = '0;
        chk("full_refill", 64'(dbg_outstanding), 64'h8);

        // Backpressure holds the pointer; reset orphans in-flight reads
        rst = 1'b1; tick(); rst = 1'b0; tick();
        core_req = 4'b0010; core_we = 4'b0000;
        settle();
        chk("bp_first_gnt", 64'(core_gnt), 64'h2);
        tick();
        core_req = 4'b1111; mem_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (core_gnt !== 4'b0000 || mem_req !== 1'b1) bad++;
            tick();
        end
        chk("bp_no_grant", 64'(bad), 64'h0);
        mem_ready = 1'b1;
        settle();
        chk("bp_ptr_held", 64'(core_gnt), 64'h4);
        tick();
        core_req = '0;
        chk("bp_outstanding", 64'(dbg_outstanding), 64'h2);
        rst = 1'b1;
        settle();
        chk("orph_flush", 64'(dbg_outstanding), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("orph_err_clear", 64'(err_orphan), 64'h0);
        mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
        tick();
        chk("orph_valid0", 64'(core_valid), 64'h0);
        chk("orph_err0", 64'(err_orphan), 64'h1);
        tick();
        mem_rvalid = 1'b0;
        chk("orph_valid1", 64'(core_valid), 64'h0);
        chk("orph_err1", 64'(err_orphan), 64'h1);
        tick();
        chk("orph_sticky", 64'(err_orphan), 64'h1);
        chk("orph_outstanding", 64'(dbg_outstanding), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Shares one external memory port among NUM_CORES `ntt_engine` instances. Each core's `arb_*` DMA port attaches to the core side, and the memory controller attaches to the mem side. Grants are round-robin, and each grant is a single-beat memory transfer. Read responses return in order and are routed back to the issuing core through a tag FIFO.

## Interface
- NUM_CORES, 4: number of requesting cores.
- ADDR_W, 48: byte address width.
- DATA_W, 64: beat width.
- TAG_DEPTH, 8: maximum outstanding reads; power of two.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- core_req  in  NUM_CORES  per-core request.
- core_we  in  NUM_CORES  per-core write enable (1 = write).
- core_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, packed the same way.
- core_gnt  out  NUM_CORES  one-hot grant; combinational, same cycle as the request.
- core_valid  out  NUM_CORES  one-hot read-data strobe; registered.
- core_rdata  out  DATA_W  read data, broadcast to all cores and qualified by core_valid; registered.
- mem_req  out  1  memory request; combinational.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; read responses arrive in issue order.
- mem_rdata  in  DATA_W  read data.
- err_orphan  out  1  sticky flag: mem_rvalid arrived while the tag FIFO was empty.
- dbg_outstanding  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy.

## Operation
- Eligibility: core i is eligible when core_req[i] & (core_we[i] | ~tag_full).
- Winner: the first eligible core scanning upward from rr_ptr, with wrap-around.
- mem_req = |eligible. mem_we, mem_addr and mem_wdata are muxed from the winner. When no core is eligible, mem_addr and mem_wdata are 0.
- A fire occurs when mem_req & mem_ready. On a fire:
  - core_gnt[winner] = 1.
  - rr_ptr <= winner+1, wrapping modulo NUM_CORES.
  - If the winner is issuing a read, push the winner's index into the tag FIFO.
- When there is no fire, core_gnt is 0 and rr_ptr holds.
- A core that holds core_req high across cycles can be granted on consecutive cycles. This is the write-streaming case.
- On mem_rvalid with the FIFO non-empty: pop the head tag. Next cycle, core_valid[tag] = 1 and core_rdata = mem_rdata.
- On mem_rvalid with the FIFO empty: set err_orphan (cleared only by rst). No core_valid is asserted and the response is dropped.
- A push and a pop in the same cycle are both performed and occupancy is unchanged. The push is still subject to the ~tag_full eligibility rule.
- When the FIFO is full, read requesters are skipped and writes continue to be granted.
- Reset mid-operation: the tag FIFO is flushed. Responses that were in flight are then orphans and raise err_orphan. The external memory must be reset together with the arbiter.

## Timing
- Grant latency: 0 cycles. core_gnt is combinational on core_req and mem_ready, and the request is consumed at the same clock edge.
- Read response latency, arbiter contribution: exactly 1 cycle from mem_rvalid to core_valid.
- Throughput: 1 transfer per cycle when mem_ready=1.
- There must be no combinational path from core_gnt back to core_req inside this block.
- Reset values:
  - rr_ptr = 0, FIFO empty.
  - core_valid = 0, core_rdata = 0, err_orphan = 0, dbg_outstanding = 0.
  - Combinational outputs: 0 while all core_req are 0.

## Structure
- Shared package `dma_pkg`: ADDR_W and DATA_W defaults, the beat size of 8 bytes, and a `core_id_t` width function $clog2(NUM_CORES).
- Sub-module `tag_fifo`: synchronous FIFO of core indices with DEPTH=TAG_DEPTH. Ports are push, pop, din, dout, full, empty and count.
- The round-robin pick is an inline function in the top level, not a separate module.

## Test plan
- Single read: core 2 issues a read to 0x100. Expect core_gnt=4'b0100 in the same cycle, mem_addr=0x100 and mem_we=0. Memory returns 0xDEAD three cycles later; one cycle after that, expect core_valid=4'b0100 and core_rdata=0xDEAD.
- Round-robin: all four cores hold read requests with mem_ready=1. Expect grant order 0, 1, 2, 3, 0. Responses come back in order and the core_valid sequence matches the grant order.
- Write stream: core 1 holds core_req high for 4096 beats with mem_ready=1. Expect 4096 consecutive grants and mem_we=1 on every beat. dbg_outstanding stays 0.
- Full FIFO: 8 reads outstanding with no responses, then core 0 issues a read and core 3 issues a write. Expect core 3 granted and core 0 blocked. After one mem_rvalid, core 0 is granted on the next request cycle.
- Backpressure and orphan: mem_ready=0 for 5 cycles gives no grant and no rr_ptr change. Then assert rst while 2 reads are in flight and deliver those 2 responses after reset. Expect err_orphan=1 and core_valid to stay 0.
